// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial N-bit adder driving a 1-bit full-adder cell

// Combinational 1-bit full adder cell
module full_adder (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (ci & (x ^ y));
endmodule

// Bit-serial adder: one operand bit per cycle, LSB first, start/busy/done handshake
module serial_adder #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         c_in,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] sum,
  output logic         c_out
);
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [N-1:0]   a_sh;
  logic [N-1:0]   b_sh;
  logic [N-1:0]   s_sh;
  logic [N-1:0]   s_nxt;
  logic           carry;
  logic [CW-1:0]  cnt;
  logic           fa_s;
  logic           fa_co;
  logic           load;
  logic           step;
  logic           finish;

  full_adder u_fa (
    .x  (a_sh[0]),
    .y  (b_sh[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  // New sum bit enters at the MSB so the LSB-first stream lands in order
  generate
    if (N == 1) begin : g_one
      assign s_nxt = fa_s;
    end else begin : g_wide
      assign s_nxt = {fa_s, s_sh[N-1:1]};
    end
  endgenerate

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and datapath controls; start is only honoured in IDLE and DONE
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (cnt == LAST) begin
          finish    = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand/sum shift registers, carry and bit counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh  <= '0;
      b_sh  <= '0;
      s_sh  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
    end else if (load) begin
      a_sh  <= a;
      b_sh  <= b;
      s_sh  <= '0;
      carry <= c_in;
      cnt   <= '0;
    end else if (step) begin
      a_sh  <= a_sh >> 1;
      b_sh  <= b_sh >> 1;
      s_sh  <= s_nxt;
      carry <= fa_co;
      cnt   <= cnt + CW'(1);
    end
  end

  // Result registers update only on the completing edge and hold otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum   <= '0;
      c_out <= 1'b0;
    end else if (finish) begin
      sum   <= s_nxt;
      c_out <= fa_co;
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);
endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - scoreboard bench for serial_adder at N=8 and N=2
`timescale 1ns/1ps
module tb_serial_adder;
  logic clk = 1'b0;
  logic rst_n;

  logic       start8, ci8, busy8, done8, co8;
  logic [7:0] a8, b8, sum8;
  logic       start2, ci2, busy2, done2, co2;
  logic [1:0] a2, b2, sum2;

  int checks   = 0;
  int failures = 0;

  logic [8:0] exp8[$];
  logic [2:0] exp2[$];
  logic [8:0] last8;
  logic [2:0] last2;

  always #5 clk = ~clk;

  serial_adder #(.N(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .c_in(ci8),
    .busy(busy8), .done(done8), .sum(sum8), .c_out(co8)
  );

  serial_adder #(.N(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2), .c_in(ci2),
    .busy(busy2), .done(done2), .sum(sum2), .c_out(co2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitors: pop the expected result whenever a DUT signals done
  always @(negedge clk) begin
    if (done8) begin
      if (exp8.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb8_unexpected_done: got done with empty queue expected none at %0t", $time);
      end else begin
        logic [8:0] e;
        e = exp8.pop_front();
        chk("sb8_result", {23'd0, co8, sum8}, {23'd0, e});
      end
    end
    if (done2) begin
      if (exp2.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb2_unexpected_done: got done with empty queue expected none at %0t", $time);
      end else begin
        logic [2:0] e;
        e = exp2.pop_front();
        chk("sb2_result", {29'd0, co2, sum2}, {29'd0, e});
      end
    end
  end

  // One N=8 operation with latency/hold checks; optional ignored start pulse in RUN
  task automatic op8(input logic [7:0] av, input logic [7:0] bv, input logic cv, input bit repulse);
    logic [8:0] r;
    r = {1'b0, av} + {1'b0, bv} + {8'd0, cv};
    @(posedge clk); #1;
    start8 = 1'b1; a8 = av; b8 = bv; ci8 = cv;
    exp8.push_back(r);
    @(posedge clk); #1;
    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); ci8 = 1'($urandom);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("busy8_run", {31'd0, busy8}, 32'd1);
      chk("done8_run", {31'd0, done8}, 32'd0);
      chk("hold8_run", {23'd0, co8, sum8}, {23'd0, last8});
      if (repulse && k == 2) begin
        start8 = 1'b1; a8 = 8'h12; b8 = 8'h34; ci8 = 1'b0;
      end
      if (repulse && k == 3) start8 = 1'b0;
    end
    @(negedge clk);
    chk("done8_pulse", {30'd0, busy8, done8}, 32'd1);
    last8 = r;
  endtask

  // One N=2 operation; done must appear on the third sample after start
  task automatic op2(input logic [1:0] av, input logic [1:0] bv, input logic cv);
    logic [2:0] r;
    r = {1'b0, av} + {1'b0, bv} + {2'd0, cv};
    @(posedge clk); #1;
    start2 = 1'b1; a2 = av; b2 = bv; ci2 = cv;
    exp2.push_back(r);
    @(posedge clk); #1;
    start2 = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("busy2_run", {30'd0, busy2, done2}, 32'd2);
      chk("hold2_run", {29'd0, co2, sum2}, {29'd0, last2});
    end
    @(negedge clk);
    chk("done2_pulse", {30'd0, busy2, done2}, 32'd1);
    last2 = r;
  endtask

  task automatic idle_hold8(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      chk("hold8_idle", {22'd0, busy8, co8, sum8}, {23'd0, last8});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int gap;
    rst_n = 1'b0;
    start8 = 0; a8 = 0; b8 = 0; ci8 = 0;
    start2 = 0; a2 = 0; b2 = 0; ci2 = 0;
    last8 = '0; last2 = '0;
    #12;
    chk("reset8_outputs", {21'd0, busy8, done8, co8, sum8}, 32'd0);
    chk("reset2_outputs", {27'd0, busy2, done2, co2, sum2}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed N=8 cases
    op8(8'h37, 8'h2C, 1'b0, 1'b0);
    chk("dir_37_2c", {23'd0, last8}, 32'h063);
    op8(8'hFF, 8'h01, 1'b0, 1'b0);
    idle_hold8(3);
    op8(8'hA5, 8'h5A, 1'b1, 1'b0);
    idle_hold8(4);
    op8(8'h4E, 8'h21, 1'b1, 1'b1);

    // Back-to-back: start held through RUN, second op captured in DONE
    @(posedge clk); #1;
    start8 = 1'b1; a8 = 8'h10; b8 = 8'h20; ci8 = 1'b0;
    exp8.push_back(9'h030);
    exp8.push_back(9'h100);
    @(posedge clk); #1;
    a8 = 8'h80; b8 = 8'h80; ci8 = 1'b0;
    for (int k = 0; k < 8; k++) @(negedge clk);
    @(negedge clk);
    chk("b2b_first_done", {31'd0, done8}, 32'd1);
    @(posedge clk); #1;
    start8 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("b2b_busy", {30'd0, busy8, done8}, 32'd2);
      chk("b2b_hold", {23'd0, co8, sum8}, 32'h030);
    end
    @(negedge clk);
    chk("b2b_second_done", {31'd0, done8}, 32'd1);
    last8 = 9'h100;

    // Asynchronous reset in the middle of RUN
    @(posedge clk); #1;
    start8 = 1'b1; a8 = 8'h77; b8 = 8'h11; ci8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy8}, 32'd0);
    chk("abort_done", {31'd0, done8}, 32'd0);
    chk("abort_sum", {24'd0, sum8}, 32'd0);
    chk("abort_cout", {31'd0, co8}, 32'd0);
    last8 = '0;
    last2 = '0;
    @(negedge clk);
    rst_n = 1'b1;
    op8(8'h01, 8'h01, 1'b0, 1'b0);
    chk("after_reset", {23'd0, last8}, 32'h002);

    // Randomised N=8 operations with random idle gaps
    for (int i = 0; i < 25; i++) begin
      op8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom_range(0, 1)));
      gap = $urandom_range(0, 3);
      idle_hold8(gap);
    end

    // Exhaustive N=2 sweep
    for (int ci = 0; ci < 2; ci++)
      for (int ai = 0; ai < 4; ai++)
        for (int bi = 0; bi < 4; bi++)
          op2(2'(ai), 2'(bi), 1'(ci));

    repeat (3) @(negedge clk);
    chk("sb8_drained", exp8.size(), 32'd0);
    chk("sb2_drained", exp2.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
